// File: rtl/tone_sequencer.sv
// Steps through a loaded note pattern, sounding each note for NOTE_CYCLES
// and then holding a GAP_CYCLES silence; pulses done when the pattern ends.
module tone_sequencer #(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int MAX_LEN     = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [$clog2(MAX_LEN)-1:0]   wr_addr,
  input  logic [2:0]                   wr_note,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic                         start,
  input  logic                         abort,
  output logic [2:0]                   thing,
  output logic                         SE,
  output logic                         busy,
  output logic                         done
);

  localparam int AW   = $clog2(MAX_LEN);
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int MAXC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t          state;
  logic [2:0]      mem [MAX_LEN];
  logic [AW-1:0]   idx;
  logic [LW-1:0]   len_q;
  logic [CW-1:0]   cnt;
  logic            wr_ok;
  logic            last;
  logic [2:0]      first_note;

  assign wr_ok = wr_en && (state == IDLE) && (int'(wr_addr) < MAX_LEN);
  assign last  = (LW'(idx) == (len_q - LW'(1)));
  // A write to address 0 in the start cycle must be the note that plays first.
  assign first_note = (wr_ok && (wr_addr == '0)) ? wr_note : mem[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_note;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      thing <= '0;
      SE    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              len_q <= (len > LEN_MAX) ? LEN_MAX : len;
              idx   <= '0;
              cnt   <= NOTE_LOAD;
              thing <= first_note;
              SE    <= 1'b1;
              busy  <= 1'b1;
              state <= NOTE;
            end
          end
        end
        NOTE: begin
          if (abort) begin
            SE    <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == '0) begin
            cnt   <= GAP_LOAD;
            SE    <= 1'b0;
            state <= GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == '0) begin
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= idx + AW'(1);
              thing <= mem[idx + AW'(1)];
              cnt   <= NOTE_LOAD;
              SE    <= 1'b1;
              state <= NOTE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          SE    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with NOTE_CYCLES=4, GAP_CYCLES=2, MAX_LEN=8.
module tb_tone_sequencer;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_note;
  logic [3:0] len;
  logic       start;
  logic       abort;
  logic [2:0] thing;
  logic       SE;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  tone_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(2), .MAX_LEN(8)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_note(wr_note), .len(len), .start(start), .abort(abort),
    .thing(thing), .SE(SE), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_note;
    logic [3:0] len;
    logic       exp_se;
    logic       exp_busy;
    logic       exp_done;
    logic [2:0] exp_thing;
  } vec_t;

  vec_t tbl [38];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_note = '0; len = '0;
  endtask

  task automatic write_note(input logic [2:0] a, input logic [2:0] n);
    wr_en = 1'b1; wr_addr = a; wr_note = n;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int busy_cnt;
    int note_cnt;
    int se_cnt;
    int done_cnt;
    logic se_prev;
    logic got_done;

    idle_inputs();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_se", SE, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_thing", thing, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    write_note(3'd0, 3'd3);
    write_note(3'd1, 3'd0);
    write_note(3'd2, 3'd7);

    // Two back-to-back plays of 3,0,7; the second one is poked with a write and a start mid-run.
    for (int r = 0; r < 38; r++) begin
      c = (r < 19) ? r + 1 : r - 18;
      tbl[r] = '{default: '0};
      tbl[r].exp_se    = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 10)) || ((c >= 13) && (c <= 16));
      tbl[r].exp_busy  = (c <= 18);
      tbl[r].exp_done  = (c == 19);
      tbl[r].exp_thing = (c <= 6) ? 3'd3 : ((c <= 12) ? 3'd0 : 3'd7);
    end
    tbl[0].start = 1'b1;  tbl[0].len = 4'd3;
    tbl[19].start = 1'b1; tbl[19].len = 4'd3;
    tbl[21].wr_en = 1'b1; tbl[21].wr_addr = 3'd1; tbl[21].wr_note = 3'd5;
    tbl[21].start = 1'b1; tbl[21].len = 4'd1;

    for (int r = 0; r < 38; r++) begin
      start = tbl[r].start; abort = tbl[r].abort; wr_en = tbl[r].wr_en;
      wr_addr = tbl[r].wr_addr; wr_note = tbl[r].wr_note; len = tbl[r].len;
      step();
      chk($sformatf("vec%0d_se", r), SE, tbl[r].exp_se);
      chk($sformatf("vec%0d_busy", r), busy, tbl[r].exp_busy);
      chk($sformatf("vec%0d_done", r), done, tbl[r].exp_done);
      chk($sformatf("vec%0d_thing", r), thing, tbl[r].exp_thing);
    end
    idle_inputs();
    step();
    chk("post_done", done, 0);

    // Abort in the second cycle of note 2.
    start = 1'b1; len = 4'd3;
    step();
    idle_inputs();
    repeat (7) step();
    chk("abort_pre_thing", thing, 0);
    chk("abort_pre_se", SE, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_se", SE, 0);
    chk("abort_busy", busy, 0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    chk("replay_thing", thing, 3);
    chk("replay_se", SE, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("replay_abort_busy", busy, 0);

    // Write and start in the same idle cycle.
    wr_en = 1'b1; wr_addr = 3'd0; wr_note = 3'd6; start = 1'b1; len = 4'd1;
    step();
    idle_inputs();
    chk("wrstart_thing", thing, 6);
    chk("wrstart_se", SE, 1);
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      step();
      if (done) got_done = 1'b1;
    end
    chk("wrstart_done", got_done, 1);

    // Abort wins over start in idle.
    start = 1'b1; abort = 1'b1; len = 4'd3;
    step();
    idle_inputs();
    chk("abort_prio_busy", busy, 0);
    chk("abort_prio_se", SE, 0);
    step();
    chk("abort_prio_done", done, 0);

    // Zero length.
    start = 1'b1; len = 4'd0;
    step();
    idle_inputs();
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_se", SE, 0);
    step();
    chk("len0_done_clr", done, 0);
    chk("len0_busy2", busy, 0);

    // Asynchronous reset between edges during playback.
    start = 1'b1; len = 4'd3;
    step();
    idle_inputs();
    step();
    chk("prerst_thing", thing, 6);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_se", SE, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_thing", thing, 0);
    step();
    #3 reset_n = 1'b1;
    repeat (3) step();
    chk("postrst_se", SE, 0);
    chk("postrst_busy", busy, 0);
    chk("postrst_thing", thing, 0);
    start = 1'b1; len = 4'd1;
    step();
    idle_inputs();
    chk("memclr_thing", thing, 0);
    chk("memclr_se", SE, 1);
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      step();
      if (done) got_done = 1'b1;
    end
    chk("memclr_done", got_done, 1);

    // Length 9 is clamped to 8 notes.
    start = 1'b1; len = 4'd9;
    busy_cnt = 0; note_cnt = 0; se_cnt = 0; done_cnt = 0; se_prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (SE) se_cnt++;
      if (SE && !se_prev) note_cnt++;
      if (done) done_cnt++;
      se_prev = SE;
    end
    idle_inputs();
    chk("clamp_busy_cycles", busy_cnt, 48);
    chk("clamp_notes", note_cnt, 8);
    chk("clamp_se_cycles", se_cnt, 32);
    chk("clamp_done", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a stored sequence of notes (the game's colour pattern) as timed tone bursts. It sits directly upstream of the speaker stage and drives that stage's 3-bit tone select and speaker-enable inputs. The game controller loads note codes into an internal sequence memory, then pulses `start`. The block steps through the notes, emitting each for a fixed on-time followed by a silent gap, and pulses `done` when the pattern completes.

## Interface
Parameters:
- `NOTE_CYCLES`, default 25_000_000: clock cycles each note sounds (0.5 s at 50 MHz); must be ≥ 1.
- `GAP_CYCLES`, default 12_500_000: silent clock cycles after each note; must be ≥ 1.
- `MAX_LEN`, default 32: sequence memory depth in notes; must be ≥ 2.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: write `wr_note` into memory at `wr_addr`.
- `wr_addr`  in  clog2(MAX_LEN): memory write address.
- `wr_note`  in  3: note code 0–7.
- `len`  in  clog2(MAX_LEN+1): number of notes to play; sampled on `start`.
- `start`  in  1: begin playback; single-cycle pulse.
- `abort`  in  1: stop playback immediately.
- `thing`  out  3: tone select to the speaker stage; registered.
- `SE`  out  1: speaker enable; registered.
- `busy`  out  1: high while a sequence is playing.
- `done`  out  1: one-cycle pulse when a sequence finishes normally.

## Operation
- Reset (asynchronous, takes effect without a clock edge):
  - FSM goes to IDLE.
  - `thing`=0, `SE`=0, `busy`=0, `done`=0.
  - All memory entries cleared to 0.
  - Note index and cycle counter cleared.
- FSM states:
  - IDLE: `SE`=0, `busy`=0, `thing` holds its last value.
    - `start` with `len`≥1: latch `min(len, MAX_LEN)`, set index to 0, load counter with NOTE_CYCLES-1, set `thing`=mem[0], go to NOTE.
    - `start` with `len`=0: stay in IDLE; pulse `done` in the next cycle.
  - NOTE: `SE`=1, `busy`=1, `thing`=mem[index].
    - Counter decrements each cycle.
    - At counter 0: load counter with GAP_CYCLES-1, go to GAP.
  - GAP: `SE`=0, `busy`=1.
    - Counter decrements each cycle.
    - At counter 0, last note (index = latched length − 1): go to IDLE and pulse `done`.
    - At counter 0, otherwise: increment index, set `thing`=mem[index+1], load counter with NOTE_CYCLES-1, go to NOTE.
- Memory writes:
  - `wr_en` is honoured only in IDLE; writes while `busy`=1 are ignored.
  - `wr_addr` ≥ MAX_LEN is ignored.
  - A write and `start` in the same IDLE cycle: the write lands first, so the new value is played.
- Abort:
  - `abort` in NOTE or GAP: next cycle is IDLE with `SE`=0, `busy`=0, and no `done`.
  - In IDLE, `abort` has priority over `start`, so playback does not begin.
- `start` while `busy`=1 is ignored.
- Counter width is clog2(max(NOTE_CYCLES, GAP_CYCLES)). The index never wraps, because the length is clamped to MAX_LEN.

## Timing
- `start` sampled high at edge k: `SE`=1 and `busy`=1 from cycle k+1.
- Each note: `SE` high for exactly NOTE_CYCLES cycles, then low for exactly GAP_CYCLES cycles.
- `thing` changes only in the cycle where NOTE is entered; it is stable for the whole note and its gap.
- Total `busy` duration is L×(NOTE_CYCLES+GAP_CYCLES) cycles, where L is the latched length.
- `done` is high for exactly one cycle: the first IDLE cycle after the last gap, when `busy`=0.
- A new `start` is accepted in that same `done` cycle.

## Test plan
Simulate with NOTE_CYCLES=4, GAP_CYCLES=2, MAX_LEN=8.
- Reset: assert `reset_n`=0 mid-run between edges -> `SE`, `busy`, `done`, `thing` go to 0 immediately; they stay 0 until `start` after release.
- Basic sequence: write 3,0,7 to addresses 0–2; `len`=3; `start` at edge 0 ->
  - `SE`=1 on cycles 1–4 (`thing`=3), 7–10 (`thing`=0), 13–16 (`thing`=7).
  - `SE`=0 on cycles 5–6, 11–12, 17–18.
  - `busy`=1 on cycles 1–18; `done`=1 only on cycle 19.
- Empty and clamped lengths:
  - `len`=0 with `start` -> `done` pulse the next cycle; `SE` and `busy` never rise.
  - `len`=9 -> exactly 8 notes play; `busy` lasts 48 cycles.
- Abort: assert `abort` in the 2nd cycle of note 2 -> `SE`=0 and `busy`=0 next cycle, `done` never pulses; a following `start` replays from note 0.
- Busy protection: `wr_en` to address 1 and a second `start` during playback -> memory unchanged, sequence timing unchanged. Write+`start` in the same IDLE cycle -> the newly written note plays.
- Back-to-back: `start` asserted in the `done` cycle -> `SE` rises the following cycle; the second sequence timing is identical to the first.
